multi_channel_arbiter_pipeline: RTL and testbench
=================================================

Name: multi_channel_arbiter_pipeline

Overview:
N-channel generalisation of the two-pipeline wrapper that sits between the producer and consumer FSMs. Each channel has a private input FIFO with valid/ready backpressure. A configurable arbiter, either round-robin or fixed-priority, grants at most one channel per cycle into a single shared RES_LAT-stage compute pipeline. Per-channel flush purges that channel's FIFO and kills its in-flight beats; results return to per-channel output lanes.

Parameters:
NUM_CH, 4, number of channels (2..16)
DATA_W, 32, data width per channel
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
RES_LAT, 2, shared resource pipeline stages (>=1)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (ch0 highest)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high
in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  per-channel input valid
in_ready  output  NUM_CH  per-channel FIFO not full
flush  input  NUM_CH  per-channel flush request, level-sampled
out_data  output  NUM_CH*DATA_W  per-channel result lanes
out_valid  output  NUM_CH  one-cycle result strobe per lane
grant  output  NUM_CH  one-hot grant issued this cycle (observability)

Behaviour:
- Reset (clk edge with reset=1):
  - all FIFOs empty; in_ready = all 1s
  - RR pointer = 0; all pipeline stages invalid
  - out_valid = 0, out_data = 0, grant = 0
- Push:
  - in_ready[i] = !full[i], a registered-count decode.
  - Push happens on an edge with in_valid[i] & in_ready[i] & !flush[i].
  - A full FIFO refuses a push even if it is popped in the same cycle.
- Grant:
  - Combinational each cycle.
  - Eligible channels are those with !empty[i] & !flush[i].
  - No eligible channel means grant = 0.
  - Round-robin: search upward from the pointer with wrap; after granting g, pointer <= (g+1) mod NUM_CH; the pointer is unchanged when there is no grant.
  - Fixed priority: grant the lowest eligible index.
- Pop:
  - The granted FIFO head is popped at the edge.
  - Stage 0 captures {valid=1, ch=g, data=head}.
  - Push and pop on the same non-full channel in the same cycle are both honoured; count is unchanged.
- Shared op: result = data + 1, modulo 2^DATA_W (wraps 0xFFFFFFFF -> 0).
- Pipeline:
  - Stages advance every cycle; there are no stalls, and the consumer always accepts.
  - When the final stage is valid, out_valid[ch] pulses for one cycle and out_data lane ch updates.
  - Other lanes hold their last value.
- Latency:
  - A beat accepted at edge k into an empty FIFO, with no competition, is granted in cycle k..k+1.
  - out_valid is visible after edge k+1+RES_LAT.
  - Each subsequent granted beat adds 1 cycle.
- Ordering: per-channel order is preserved. Cross-channel order follows the grant sequence.
- Flush[i] on an edge:
  - FIFO i count <= 0.
  - Any push on channel i that edge is discarded.
  - Channel i is ineligible for grant that cycle.
  - Every pipeline stage holding ch==i has valid cleared, including the stage being loaded and the output register, so out_valid[i] = 0 on the following cycle.
  - Other channels are unaffected.
  - Flush held for multiple cycles keeps channel i empty and in_ready[i] = 1.
- Reset mid-operation: all in-flight beats are dropped and no out_valid is produced afterwards; state is as in Reset.
- Throughput: one beat per cycle aggregate. With all channels continuously non-empty, round-robin gives each channel 1/NUM_CH of the cycles.

Test Plan:
1. Single beat, NUM_CH=4, RES_LAT=2, ARB_MODE=0: push 0x00000010 on ch2 at edge 0. Required: grant=4'b0100 in cycle 1, out_valid=4'b0100 with lane 2 = 0x00000011 after edge 3, and no other out_valid.
2. Round-robin fairness: all 4 FIFOs preloaded with 3 beats each, then released. Required: grants cycle ch0,1,2,3,0,1,2,3,0,1,2,3, and per-channel results are in push order.
3. Fixed priority (ARB_MODE=1): ch0 and ch3 each hold 2 beats. Required: grants ch0,ch0,ch3,ch3.
4. Backpressure: push 5 beats on ch1 with arbitration blocked by holding flush on ch1 only after pre-filling, or with grants starved by priority. Required: in_ready[1]=0 after the 4th push; the 5th beat is not accepted until a pop.
5. Flush mid-flight: ch0 has 3 beats queued and 1 beat in stage 0; assert flush[0] for one cycle. Required: no further out_valid[0], in_ready[0]=1 next cycle, and ch1 beats in flight still emerge with correct values.
6. Wrap and reset: push 0xFFFFFFFF on ch3. Required: lane 3 = 0x00000000. Then assert reset with beats in flight. Required: out_valid stays 0, grant=0 and in_ready=4'b1111 from the next cycle.

Source files
------------

// File: rtl/multi_channel_arbiter_pipeline_if.sv
// multi_channel_arbiter_pipeline_if: per-channel input/flush/output bundle for the arbiter pipeline
interface multi_channel_arbiter_pipeline_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        flush;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        grant;
  modport master (output in_data, in_valid, flush, input in_ready, out_data, out_valid, grant);
  modport slave  (input in_data, in_valid, flush, output in_ready, out_data, out_valid, grant);
endinterface

// File: rtl/multi_channel_arbiter_pipeline.sv
// multi_channel_arbiter_pipeline: per-channel FIFOs arbitrated into a shared +1 pipeline with per-channel flush
module multi_channel_arbiter_pipeline #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RES_LAT    = 2,
  parameter int ARB_MODE   = 0
) (
  input logic clk,
  input logic reset,
  multi_channel_arbiter_pipeline_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  logic [DATA_W-1:0]        mem_q [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0]        mem_d [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]            rd_q [NUM_CH], rd_d [NUM_CH];
  logic [AW-1:0]            wr_q [NUM_CH], wr_d [NUM_CH];
  logic [NW-1:0]            cnt_q [NUM_CH], cnt_d [NUM_CH];
  logic [CW-1:0]            ptr_q, ptr_d, gnt_idx;
  logic [NUM_CH-1:0]        gnt, elig, full, push;
  logic                     found;
  int                       idx;
  logic [RES_LAT-1:0]       st_v_q, st_v_d;
  logic [CW-1:0]            st_ch_q [RES_LAT], st_ch_d [RES_LAT];
  logic [DATA_W-1:0]        st_data_q [RES_LAT], st_data_d [RES_LAT];
  logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  // first eligible channel scanning upward from the start index with wrap
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    idx = 0;
    full = '0;
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i] = cnt_q[i] == NW'(FIFO_DEPTH);
      elig[i] = (cnt_q[i] != '0) && !bus.flush[i];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE != 0 ? 0 : int'(ptr_q)) + k;
      idx = idx >= NUM_CH ? idx - NUM_CH : idx;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
    ptr_d = !found ? ptr_q : (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CW'(1);
  end
  always_comb begin
    mem_d = mem_q;
    push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i] = bus.in_valid[i] && !full[i] && !bus.flush[i];
      if (push[i]) mem_d[i][wr_q[i]] = bus.in_data[i*DATA_W +: DATA_W];
      wr_d[i] = bus.flush[i] ? '0 : wr_q[i] + AW'(push[i]);
      rd_d[i] = bus.flush[i] ? '0 : rd_q[i] + AW'(gnt[i]);
      cnt_d[i] = bus.flush[i] ? '0 : cnt_q[i] + NW'(push[i]) - NW'(gnt[i]);
    end
  end
  // flushed channels lose every in-flight beat, including the one reaching the output register
  always_comb begin
    st_v_d = '0;
    st_ch_d = st_ch_q;
    st_data_d = st_data_q;
    st_v_d[0] = found;
    st_ch_d[0] = gnt_idx;
    st_data_d[0] = mem_q[gnt_idx][rd_q[gnt_idx]];
    for (int s = 1; s < RES_LAT; s++) begin
      st_v_d[s] = st_v_q[s-1] && !bus.flush[st_ch_q[s-1]];
      st_ch_d[s] = st_ch_q[s-1];
      st_data_d[s] = st_data_q[s-1];
    end
    out_valid_d = '0;
    out_data_d = out_data_q;
    if (st_v_q[RES_LAT-1] && !bus.flush[st_ch_q[RES_LAT-1]]) begin
      out_valid_d[st_ch_q[RES_LAT-1]] = 1'b1;
      out_data_d[int'(st_ch_q[RES_LAT-1])*DATA_W +: DATA_W] = st_data_q[RES_LAT-1] + DATA_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '{default: '0};
      wr_q <= '{default: '0};
      cnt_q <= '{default: '0};
      ptr_q <= '0;
      st_v_q <= '0;
      out_valid_q <= '0;
      out_data_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      st_v_q <= st_v_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    st_ch_q <= st_ch_d;
    st_data_q <= st_data_d;
  end
  assign bus.in_ready  = ~full;
  assign bus.grant     = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_multi_channel_arbiter_pipeline.sv
// tb_multi_channel_arbiter_pipeline: round-robin and fixed-priority instances driven alike, checked against a queue model
module tb_multi_channel_arbiter_pipeline;
  localparam int NUM_CH = 4, DATA_W = 32, FIFO_DEPTH = 4, RES_LAT = 2;
  typedef struct packed {logic [DATA_W-1:0] data; int ch; int due;} beat_t;
  typedef logic [DATA_W-1:0] dq_t [$];
  typedef beat_t bq_t [$];
  logic clk = 1'b0, rst_in;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0] in_valid, flush;
  int n_tests = 0, n_fail = 0, cyc = 0, load;
  logic armed = 1'b0;
  dq_t q [2][NUM_CH];
  bq_t fly [2];
  int ptr [2];
  logic [NUM_CH-1:0] exp_ov [2];
  logic [NUM_CH*DATA_W-1:0] exp_od [2];
  multi_channel_arbiter_pipeline_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) b0 ();
  multi_channel_arbiter_pipeline_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) b1 ();
  assign b0.in_data = in_data;
  assign b0.in_valid = in_valid;
  assign b0.flush = flush;
  assign b1.in_data = in_data;
  assign b1.in_valid = in_valid;
  assign b1.flush = flush;
  multi_channel_arbiter_pipeline #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RES_LAT(RES_LAT), .ARB_MODE(0))
    dut0 (.clk(clk), .reset(rst_in), .bus(b0.slave));
  multi_channel_arbiter_pipeline #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RES_LAT(RES_LAT), .ARB_MODE(1))
    dut1 (.clk(clk), .reset(rst_in), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [NUM_CH*DATA_W-1:0] act, input logic [NUM_CH*DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // model: each negedge checks the DUTs, then applies the upcoming edge to per-channel queues
  always @(negedge clk) begin : model
    logic [NUM_CH-1:0] eg, er;
    int g, st, idx;
    int pre [NUM_CH];
    beat_t b;
    bq_t keep;
    for (int m = 0; m < 2; m++) begin
      g = -1;
      st = m != 0 ? 0 : ptr[m];
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (st + k) % NUM_CH;
        if (g < 0 && q[m][idx].size() > 0 && !flush[idx]) g = idx;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int i = 0; i < NUM_CH; i++) er[i] = q[m][i].size() < FIFO_DEPTH;
      if (armed) begin
        check($sformatf("m%0d grant", m), m != 0 ? b1.grant : b0.grant, eg);
        check($sformatf("m%0d in_ready", m), m != 0 ? b1.in_ready : b0.in_ready, er);
        check($sformatf("m%0d out_valid", m), m != 0 ? b1.out_valid : b0.out_valid, exp_ov[m]);
        check($sformatf("m%0d out_data", m), m != 0 ? b1.out_data : b0.out_data, exp_od[m]);
      end
      if (rst_in) begin
        for (int i = 0; i < NUM_CH; i++) q[m][i].delete();
        fly[m].delete();
        ptr[m] = 0;
        exp_ov[m] = '0;
        exp_od[m] = '0;
      end else begin
        keep.delete();
        exp_ov[m] = '0;
        foreach (fly[m][j]) begin
          b = fly[m][j];
          if (flush[b.ch]) continue;
          if (b.due == cyc) begin
            exp_ov[m][b.ch] = 1'b1;
            exp_od[m][b.ch*DATA_W +: DATA_W] = b.data + 1;
          end else keep.push_back(b);
        end
        fly[m] = keep;
        for (int i = 0; i < NUM_CH; i++) pre[i] = q[m][i].size();
        if (g >= 0) begin
          b.ch = g;
          b.data = q[m][g].pop_front();
          b.due = cyc + RES_LAT;
          fly[m].push_back(b);
          if (m == 0) ptr[m] = (g + 1) % NUM_CH;
        end
        for (int i = 0; i < NUM_CH; i++)
          if (flush[i]) q[m][i].delete();
          else if (in_valid[i] && pre[i] < FIFO_DEPTH) q[m][i].push_back(in_data[i*DATA_W +: DATA_W]);
      end
    end
    if (rst_in) armed = 1'b1;
    cyc++;
  end
  initial begin
    rst_in = 1'b1;
    in_valid = '0;
    flush = '0;
    in_data = '0;
    repeat (3) tick();
    rst_in = 1'b0;
    repeat (2) tick();
    in_data[2*DATA_W +: DATA_W] = 32'h10;
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    @(negedge clk);
    check("t1 grant", b0.grant, 4'b0100);
    repeat (3) tick();
    @(negedge clk);
    check("t1 out_valid", b0.out_valid, 4'b0100);
    check("t1 lane2", b0.out_data[2*DATA_W +: DATA_W], 32'h11);
    repeat (4) tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
      in_valid = 4'b1111;
      tick();
    end
    in_valid = '0;
    repeat (20) tick();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
      in_valid = 4'b0011;
      tick();
    end
    in_valid = '0;
    flush = 4'b0001;
    tick();
    flush = '0;
    @(negedge clk);
    check("t5 in_ready0", b0.in_ready[0], 1'b1);
    check("t5 out_valid0", b0.out_valid[0], 1'b0);
    repeat (10) tick();
    in_data[3*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
    in_valid = 4'b1000;
    tick();
    in_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("t6 out_valid", b0.out_valid, 4'b1000);
    check("t6 lane3 wrap", b0.out_data[3*DATA_W +: DATA_W], 32'h0);
    repeat (4) tick();
    in_valid = 4'b0011;
    repeat (4) tick();
    @(negedge clk);
    check("t4 fp ready1", b1.in_ready[1], 1'b0);
    repeat (2) tick();
    @(negedge clk);
    check("t4 fp ready1 held", b1.in_ready[1], 1'b0);
    in_valid = 4'b0010;
    repeat (12) tick();
    in_valid = 4'b1111;
    repeat (3) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    in_valid = '0;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      check("t6 rst out_valid", b0.out_valid, '0);
      check("t6 rst grant", b0.grant, '0);
      check("t6 rst in_ready", b0.in_ready, 4'b1111);
      tick();
    end
    for (int r = 0; r < 3000; r++) begin
      if (r % 250 == 0) load = $urandom_range(10, 100);
      for (int i = 0; i < NUM_CH; i++) begin
        in_valid[i] = $urandom_range(0, 99) < load;
        in_data[i*DATA_W +: DATA_W] = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFF : $urandom;
        flush[i] = $urandom_range(0, 29) == 0;
      end
      rst_in = $urandom_range(0, 499) == 0;
      tick();
    end
    rst_in = 1'b0;
    in_valid = '0;
    flush = '0;
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
